// File: rtl/qualidade_pkg.sv
// Shared types and constants for the belt quality classifier.
// States of the inspection FSM and the LED verdict encodings.
package qualidade_pkg;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ESPERA_RGB = 2'd1,
        AVALIA     = 2'd2,
        RESULTADO  = 2'd3
    } estado_t;

    localparam logic [1:0] LED_IDLE    = 2'b00;
    localparam logic [1:0] LED_APROV   = 2'b01;
    localparam logic [1:0] LED_REPROV  = 2'b10;
    localparam logic [1:0] LED_TIMEOUT = 2'b11;

    // Map the AND-reduced channel result onto the LED code
    function automatic logic [1:0] veredito(input logic todos_ok);
        return todos_ok ? LED_APROV : LED_REPROV;
    endfunction

endpackage

// File: rtl/qualidade_classificador_if.sv
// Bus between the sensor front-end / LED board and the quality classifier.
// master = environment side, slave = classifier side.
interface qualidade_classificador_if #(
    parameter int N_CANAIS = 3,
    parameter int W_COR    = 8,
    parameter int W_CONT   = 8
);
    logic                      presenca;
    logic [N_CANAIS*W_COR-1:0] rgb;
    logic                      rgb_valido;
    logic [N_CANAIS*W_COR-1:0] lim_min;
    logic [N_CANAIS*W_COR-1:0] lim_max;
    logic                      limpa_cont;
    logic [1:0]                leds;
    logic                      resultado;
    logic [W_CONT-1:0]         cont_aprov;
    logic [W_CONT-1:0]         cont_reprov;
    logic [W_CONT-1:0]         cont_timeout;

    modport master (
        output presenca, rgb, rgb_valido, lim_min, lim_max, limpa_cont,
        input  leds, resultado, cont_aprov, cont_reprov, cont_timeout
    );

    modport slave (
        input  presenca, rgb, rgb_valido, lim_min, lim_max, limpa_cont,
        output leds, resultado, cont_aprov, cont_reprov, cont_timeout
    );
endinterface

// File: rtl/qualidade_canal_cmp.sv
// Inclusive unsigned range check for one colour channel.
// An inverted window (lim_min > lim_max) can never be satisfied.
module qualidade_canal_cmp #(
    parameter int W_COR = 8
) (
    input  logic [W_COR-1:0] valor,
    input  logic [W_COR-1:0] lim_min,
    input  logic [W_COR-1:0] lim_max,
    output logic             ok
);
    assign ok = (valor >= lim_min) && (valor <= lim_max);
endmodule

// File: rtl/qualidade_classificador.sv
// Belt object quality classifier: waits for a colour reading while an object
// is present, checks every channel against its window and shows the verdict.
// Optional event counters are built when QUALIDADE_CONTADORES_EN is defined.
module qualidade_classificador
    import qualidade_pkg::*;
#(
    parameter int N_CANAIS       = 3,
    parameter int W_COR          = 8,
    parameter int TIMEOUT_CICLOS = 16,
    parameter int W_CONT         = 8
) (
    input logic                       clk,
    input logic                       rst,
    qualidade_classificador_if.slave  bus
);
    localparam int W_TIMER = $clog2(TIMEOUT_CICLOS);
    localparam logic [W_TIMER-1:0] TIMER_FIM = W_TIMER'(TIMEOUT_CICLOS - 1);

    estado_t                   state_reg, state_next;
    logic [W_TIMER-1:0]        timer_reg, timer_next;
    logic [1:0]                leds_reg, leds_next;
    logic                      resultado_reg, resultado_next;
    logic [N_CANAIS*W_COR-1:0] cap_reg;
    logic                      cap_en;
    logic                      inc_aprov, inc_reprov, inc_timeout;
    logic [N_CANAIS-1:0]       canal_ok;
    logic                      todos_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_CANAIS; gi++) begin : g_canal
            qualidade_canal_cmp #(.W_COR(W_COR)) u_cmp (
                .valor   (cap_reg[gi*W_COR +: W_COR]),
                .lim_min (bus.lim_min[gi*W_COR +: W_COR]),
                .lim_max (bus.lim_max[gi*W_COR +: W_COR]),
                .ok      (canal_ok[gi])
            );
        end
    endgenerate

    assign todos_ok = &canal_ok;

    // Next-state, timer and verdict decisions; presenca loss beats a strobe
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        leds_next      = leds_reg;
        resultado_next = resultado_reg;
        cap_en         = 1'b0;
        inc_aprov      = 1'b0;
        inc_reprov     = 1'b0;
        inc_timeout    = 1'b0;
        case (state_reg)
            OCIOSO: begin
                if (bus.presenca) begin
                    state_next = ESPERA_RGB;
                    timer_next = '0;
                end
            end
            ESPERA_RGB: begin
                if (!bus.presenca) begin
                    state_next = OCIOSO;
                end else if (bus.rgb_valido) begin
                    cap_en     = 1'b1;
                    state_next = AVALIA;
                end else if (timer_reg == TIMER_FIM) begin
                    state_next     = RESULTADO;
                    leds_next      = LED_TIMEOUT;
                    resultado_next = 1'b1;
                    inc_timeout    = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            AVALIA: begin
                state_next     = RESULTADO;
                leds_next      = veredito(todos_ok);
                resultado_next = 1'b1;
                inc_aprov      = todos_ok;
                inc_reprov     = !todos_ok;
            end
            RESULTADO: begin
                if (!bus.presenca) begin
                    state_next     = OCIOSO;
                    leds_next      = LED_IDLE;
                    resultado_next = 1'b0;
                end
            end
            default: state_next = OCIOSO;
        endcase
    end

    // FSM state, wait timer and registered LED outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= OCIOSO;
            timer_reg     <= '0;
            leds_reg      <= LED_IDLE;
            resultado_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            leds_reg      <= leds_next;
            resultado_reg <= resultado_next;
        end
    end

    // Colour capture so the comparison sees a stable reading in AVALIA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_reg <= '0;
        end else if (cap_en) begin
            cap_reg <= bus.rgb;
        end
    end

    assign bus.leds      = leds_reg;
    assign bus.resultado = resultado_reg;

`ifdef QUALIDADE_CONTADORES_EN
    logic [2:0]        inc_vec;
    logic [W_CONT-1:0] cont_reg [3];

    assign inc_vec = {inc_timeout, inc_reprov, inc_aprov};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_cont
            // Saturating event counter; clear wins over a coincident event
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cont_reg[gi] <= '0;
                end else if (bus.limpa_cont) begin
                    cont_reg[gi] <= '0;
                end else if (inc_vec[gi] && (cont_reg[gi] != {W_CONT{1'b1}})) begin
                    cont_reg[gi] <= cont_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.cont_aprov   = cont_reg[0];
    assign bus.cont_reprov  = cont_reg[1];
    assign bus.cont_timeout = cont_reg[2];
`else
    logic unused_sinais;
    assign unused_sinais    = &{1'b0, bus.limpa_cont, inc_aprov, inc_reprov, inc_timeout};
    assign bus.cont_aprov   = {W_CONT{1'b0}};
    assign bus.cont_reprov  = {W_CONT{1'b0}};
    assign bus.cont_timeout = {W_CONT{1'b0}};
`endif

endmodule

// File: tb/tb_qualidade_classificador.sv
// Self-checking bench for qualidade_classificador: directed scenarios with
// literal expectations plus randomized traffic against an object-level model.
// Counter expectations follow QUALIDADE_CONTADORES_EN as seen by this file.
module tb_qualidade_classificador;
    localparam int NC = 3;
    localparam int WC = 8;
    localparam int TO = 16;
    localparam int WT = 8;
`ifdef QUALIDADE_CONTADORES_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qualidade_classificador_if #(.N_CANAIS(NC), .W_COR(WC), .W_CONT(WT)) bus ();

    qualidade_classificador #(
        .N_CANAIS(NC), .W_COR(WC), .TIMEOUT_CICLOS(TO), .W_CONT(WT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- object-level reference model ----------------
    // phase: 0 no object, 1 waiting for reading, 2 judging, 3 verdict shown
    int          m_phase = 0;
    int          m_wait  = 0;
    int          m_leds  = 0;
    int          m_ap = 0, m_rp = 0, m_to = 0;
    logic [23:0] m_cap = '0;

    function automatic int julga(input logic [23:0] c, input logic [23:0] mn, input logic [23:0] mx);
        int v, lo, hi;
        for (int k = 0; k < NC; k++) begin
            v  = int'((c  >> (8*k)) & 24'hFF);
            lo = int'((mn >> (8*k)) & 24'hFF);
            hi = int'((mx >> (8*k)) & 24'hFF);
            if (v < lo || v > hi) return 2;
        end
        return 1;
    endfunction

    function automatic int sat(input int n);
        return (n >= 255) ? 255 : n + 1;
    endfunction

    // Advance the model one clock using the inputs present at the edge
    always @(posedge clk or posedge rst) begin : modelo
        int ev;
        if (rst) begin
            m_phase = 0; m_wait = 0; m_leds = 0;
            m_ap = 0; m_rp = 0; m_to = 0;
            m_cap = '0;
        end else begin
            ev = 0;
            case (m_phase)
                0: if (bus.presenca) begin m_phase = 1; m_wait = 0; end
                1: begin
                    if (!bus.presenca) m_phase = 0;
                    else if (bus.rgb_valido) begin m_cap = bus.rgb; m_phase = 2; end
                    else if (m_wait == TO - 1) begin m_leds = 3; ev = 3; m_phase = 3; end
                    else m_wait++;
                end
                2: begin
                    m_leds  = julga(m_cap, bus.lim_min, bus.lim_max);
                    ev      = m_leds;
                    m_phase = 3;
                end
                default: if (!bus.presenca) begin m_leds = 0; m_phase = 0; end
            endcase
            if (bus.limpa_cont) begin
                m_ap = 0; m_rp = 0; m_to = 0;
            end else begin
                if (ev == 1) m_ap = sat(m_ap);
                if (ev == 2) m_rp = sat(m_rp);
                if (ev == 3) m_to = sat(m_to);
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the edge
    always @(negedge clk) begin
        if (checking) begin
            chk("leds",         bus.leds,         m_leds);
            chk("resultado",    bus.resultado,    (m_phase == 3) ? 1 : 0);
            chk("cont_aprov",   bus.cont_aprov,   CONT_EN ? m_ap : 0);
            chk("cont_reprov",  bus.cont_reprov,  CONT_EN ? m_rp : 0);
            chk("cont_timeout", bus.cont_timeout, CONT_EN ? m_to : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit p, input bit v, input bit lc, input logic [23:0] c);
        @(negedge clk);
        bus.presenca   = p;
        bus.rgb_valido = v;
        bus.limpa_cont = lc;
        bus.rgb        = c;
    endtask

    // One complete object with a reading; checks the verdict, then removes it
    task automatic objeto(input logic [23:0] c, input bit lc, input int exp_leds, input string nm);
        drive(1, 0, 0, 24'h0);
        drive(1, 1, 0, c);
        drive(1, 0, lc, 24'h0);
        drive(1, 0, 0, 24'h0);
        chk(nm, bus.leds, exp_leds);
        drive(0, 0, 0, 24'h0);
        drive(0, 0, 0, 24'h0);
        chk({nm, "_idle"}, bus.leds, 0);
    endtask

    function automatic logic [23:0] cor_aleatoria();
        logic [23:0] c;
        logic [7:0]  tab [5];
        tab[0] = 8'h3F; tab[1] = 8'h40; tab[2] = 8'hC0; tab[3] = 8'hC1; tab[4] = 8'h80;
        for (int k = 0; k < NC; k++) begin
            if ($urandom_range(0, 1) == 0) c[8*k +: 8] = 8'($urandom);
            else c[8*k +: 8] = tab[$urandom_range(0, 4)];
        end
        return c;
    endfunction

    initial begin
        bus.presenca   = 1'b0;
        bus.rgb_valido = 1'b0;
        bus.limpa_cont = 1'b0;
        bus.rgb        = '0;
        bus.lim_min    = 24'h404040;
        bus.lim_max    = 24'hC0C0C0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        chk("reset_leds", bus.leds, 0);
        chk("reset_resultado", bus.resultado, 0);
        chk("reset_cont_aprov", bus.cont_aprov, 0);

        // mid-range reading approves
        objeto(24'h808080, 0, 1, "aprov_808080");
        chk("cont_aprov_1", bus.cont_aprov, CONT_EN ? 1 : 0);

        // one channel just above the window rejects; exact bounds approve
        objeto(24'h8080C1, 0, 2, "reprov_8080C1");
        chk("cont_reprov_1", bus.cont_reprov, CONT_EN ? 1 : 0);
        objeto(24'h40C040, 0, 1, "limite_40C040");

        // timeout after the 16th edge spent waiting
        drive(1, 0, 0, 24'h0);
        for (int i = 0; i < TO; i++) drive(1, 0, 0, 24'h0);
        chk("timeout_edge15", bus.leds, 0);
        drive(1, 0, 0, 24'h0);
        chk("timeout_edge16", bus.leds, 3);
        chk("cont_timeout_1", bus.cont_timeout, CONT_EN ? 1 : 0);
        drive(0, 0, 0, 24'h0);
        drive(0, 0, 0, 24'h0);

        // object leaves in the same cycle as the strobe
        drive(1, 0, 0, 24'h0);
        drive(0, 1, 0, 24'h808080);
        drive(0, 0, 0, 24'h0);
        drive(0, 0, 0, 24'h0);
        chk("saida_leds", bus.leds, 0);
        chk("saida_cont_aprov", bus.cont_aprov, CONT_EN ? 2 : 0);

        // second strobe while the verdict is shown is ignored
        drive(1, 0, 0, 24'h0);
        drive(1, 1, 0, 24'h808080);
        drive(1, 0, 0, 24'h0);
        drive(1, 1, 0, 24'h8080C1);
        drive(1, 0, 0, 24'h0);
        drive(1, 0, 0, 24'h0);
        chk("strobe_ignorado", bus.leds, 1);
        chk("strobe_cont_reprov", bus.cont_reprov, CONT_EN ? 1 : 0);

        // asynchronous reset while a verdict is displayed
        drive(0, 0, 0, 24'h0);
        drive(1, 0, 0, 24'h0);
        drive(1, 1, 0, 24'h8080C1);
        drive(1, 0, 0, 24'h0);
        drive(1, 0, 0, 24'h0);
        chk("pre_rst_leds", bus.leds, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_leds", bus.leds, 0);
        chk("rst_async_resultado", bus.resultado, 0);
        chk("rst_async_cont_aprov", bus.cont_aprov, 0);
        chk("rst_async_cont_timeout", bus.cont_timeout, 0);
        #1 rst = 1'b0;
        drive(0, 0, 0, 24'h0);
        drive(0, 0, 0, 24'h0);

        // inverted window on channel 0 always rejects
        bus.lim_min = 24'h4040A0;
        bus.lim_max = 24'hC0C090;
        objeto(24'h808095, 0, 2, "janela_invertida");
        bus.lim_min = 24'h404040;
        bus.lim_max = 24'hC0C0C0;

        // saturation of cont_aprov, then clear beating an increment
        for (int i = 0; i < 256; i++) objeto(24'h808080, 0, 1, "saturacao");
        chk("cont_aprov_sat", bus.cont_aprov, CONT_EN ? 255 : 0);
        objeto(24'h808080, 1, 1, "limpa_coincidente");
        chk("cont_aprov_limpo", bus.cont_aprov, 0);

        // randomized traffic checked cycle by cycle against the model
        begin
            bit p = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) p = ~p;
                if ($urandom_range(0, 199) == 0) begin
                    bus.lim_min = cor_aleatoria();
                    bus.lim_max = cor_aleatoria();
                end
                drive(p, ($urandom_range(0, 5) == 0), ($urandom_range(0, 63) == 0), cor_aleatoria());
                if ($urandom_range(0, 399) == 0) begin
                    #2 rst = 1'b1;
                    #2 rst = 1'b0;
                end
            end
        end

        drive(0, 0, 0, 24'h0);
        @(negedge clk);
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
